// File: rtl/ex_divider.sv
// ex_divider: iterative restoring divider, one quotient bit per clock, signed/unsigned with start/busy/done handshake.
module ex_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH:0] prem;
  logic [WIDTH-1:0] quo, dvs, cnt, abs_a, abs_b, q_fix, r_fix;
  logic [WIDTH:0] shifted, diff;
  logic neg_q, neg_r, accept, ge;
  assign accept = state == IDLE && start;
  assign abs_a = is_signed && dividend[WIDTH-1] ? -dividend : dividend;
  assign abs_b = is_signed && divisor[WIDTH-1] ? -divisor : divisor;
  // quo holds the remaining dividend bits and collects quotient bits from the bottom
  assign shifted = {prem[WIDTH-1:0], quo[WIDTH-1]};
  assign diff = shifted - {1'b0, dvs};
  assign ge = !diff[WIDTH];
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start ? (divisor == '0 ? DONE : RUN) : IDLE;
    else if (state == RUN) state_nx = cnt == '0 ? DONE : RUN;
    else state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        prem <= '0;
        quo <= abs_a;
        dvs <= abs_b;
        cnt <= WIDTH'(WIDTH);
        neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r <= is_signed && dividend[WIDTH-1];
        if (divisor == '0) begin
          quotient <= '1;
          remainder <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        if (cnt != '0) begin
          prem <= ge ? diff : shifted;
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt - 1'b1;
        end else begin
          quotient <= q_fix;
          remainder <= r_fix;
          div_by_zero <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_divider.sv
// tb_ex_divider: directed vectors with a scoreboard queue checked by an independent done monitor.
module tb_ex_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic prev_done = 1'b0;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic z;
    int lat;
    int acc;
  } exp_t;
  exp_t sb[$];

  ex_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      chk("busy_in_done", 32'(busy), 32'd1);
      chk("done_pulse_single", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
        if (e.lat >= 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end else if (prev_done) begin
      chk("busy_after_done", 32'(busy), 32'd0);
    end
    prev_done <= done;
  end

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez,
                       input logic push_it);
    int t = 0;
    while (busy && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy) chk("idle_wait_timeout", 32'(busy), 32'd0);
    start = 1'b1;
    is_signed = s;
    dividend = a;
    divisor = b;
    if (push_it) sb.push_back('{eq, er, ez, (b == 0) ? -1 : 33, cyc + 1});
    @(posedge clk);
    #1;
    start = 1'b0;
    is_signed = ~s;
    dividend = $urandom;
    divisor = $urandom;
  endtask

  logic        vs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] va[10] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h12345678, 32'h12345678,
                          32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFF9C, 32'd5};
  logic [31:0] vb[10] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd0,
                          32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd10};
  logic [31:0] vq[10] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
                          32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd14, 32'd0};
  logic [31:0] vr[10] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'h12345678, 32'h12345678,
                          32'd0, 32'd0, 32'h80000000, 32'hFFFFFFFE, 32'd5};
  logic        vz[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    for (int i = 0; i < 10; i++) issue(vs[i], va[i], vb[i], vq[i], vr[i], vz[i], 1'b1);
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    dividend = 32'd999;
    divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    issue(1'b0, 32'd12345, 32'd100, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1);
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
